// File: rtl/pwm_tone_bank.sv
// pwm_tone_bank: bank of CH independent PWM tone generators sharing one load port.
//
// Each channel runs a free counter modulo its active period and drives a registered
// PWM level (high while the counter is below duty). New period/duty values are staged
// in a shadow register and take effect at the channel's next wrap, so waveforms are
// never cut mid-period. A channel that is off (period 0) takes a load immediately.
//
// Parameters
//   N   counter, period and duty width in bits
//   CH  number of independent tone channels (>= 2)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   load_valid   load request
//   load_ready   high when the addressed channel has no load pending
//   load_ch      target channel index
//   load_period  new period in clk cycles (0 = channel off)
//   load_duty    new high-time in clk cycles
//   pwm_out      per-channel tone waveform (registered)
//   wrap         per-channel pulse in the cycle the counter sits at period-1
//   mix_count    number of channels whose pwm_out is high
//
// Configuration
//   PWM_TONE_MIX_EN  when defined, mix_count is the registered popcount of pwm_out;
//                    otherwise mix_count is tied to 0.
module pwm_tone_bank #(
  parameter int unsigned N  = 18,
  parameter int unsigned CH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [$clog2(CH)-1:0]    load_ch,
  input  logic [N-1:0]             load_period,
  input  logic [N-1:0]             load_duty,
  output logic [CH-1:0]            pwm_out,
  output logic [CH-1:0]            wrap,
  output logic [$clog2(CH+1)-1:0]  mix_count
);

  localparam int unsigned ChW  = $clog2(CH);
  localparam int unsigned MixW = $clog2(CH+1);
  // Channel count widened by one bit so out-of-range indices compare cleanly.
  localparam logic [ChW:0]   ChLim = CH[ChW:0];
  localparam logic [N-1:0]   One   = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] cnt_q    [CH];
  logic [N-1:0] cnt_d    [CH];
  logic [N-1:0] per_q    [CH];
  logic [N-1:0] per_d    [CH];
  logic [N-1:0] duty_q   [CH];
  logic [N-1:0] duty_d   [CH];
  logic [N-1:0] sh_per_q [CH];
  logic [N-1:0] sh_per_d [CH];
  logic [N-1:0] sh_duty_q[CH];
  logic [N-1:0] sh_duty_d[CH];
  logic [CH-1:0] pend_q, pend_d;
  logic [CH-1:0] pwm_q, pwm_d;
  logic [CH-1:0] wrap_c;

  logic ch_ok;
  logic accept;

  assign ch_ok      = ({1'b0, load_ch} < ChLim);
  assign load_ready = ch_ok ? !pend_q[load_ch] : 1'b0;
  assign accept     = load_valid && load_ready;

  assign pwm_out = pwm_q;
  assign wrap    = wrap_c;

  always_comb begin
    pend_d = pend_q;
    pwm_d  = '0;
    wrap_c = '0;
    for (int c = 0; c < int'(CH); c++) begin
      cnt_d[c]     = cnt_q[c];
      per_d[c]     = per_q[c];
      duty_d[c]    = duty_q[c];
      sh_per_d[c]  = sh_per_q[c];
      sh_duty_d[c] = sh_duty_q[c];

      wrap_c[c] = (per_q[c] != '0) && (cnt_q[c] == per_q[c] - One);
      pwm_d[c]  = (per_q[c] != '0) && (cnt_q[c] < duty_q[c]);

      if (per_q[c] == '0) begin
        cnt_d[c] = '0;
      end else if (wrap_c[c]) begin
        cnt_d[c] = '0;
        if (pend_q[c]) begin
          per_d[c]  = sh_per_q[c];
          duty_d[c] = sh_duty_q[c];
          pend_d[c] = 1'b0;
        end
      end else begin
        cnt_d[c] = cnt_q[c] + One;
      end

      // accept implies pend_q is clear, so this never collides with the shadow copy
      // above; a load landing on a wrap cycle therefore waits for the next wrap.
      if (accept && (load_ch == ChW'(c))) begin
        if (per_q[c] == '0) begin
          per_d[c]  = load_period;
          duty_d[c] = load_duty;
          cnt_d[c]  = '0;
        end else begin
          sh_per_d[c]  = load_period;
          sh_duty_d[c] = load_duty;
          pend_d[c]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
      pwm_q  <= '0;
      for (int c = 0; c < int'(CH); c++) begin
        cnt_q[c]     <= '0;
        per_q[c]     <= '0;
        duty_q[c]    <= '0;
        sh_per_q[c]  <= '0;
        sh_duty_q[c] <= '0;
      end
    end else begin
      pend_q <= pend_d;
      pwm_q  <= pwm_d;
      for (int c = 0; c < int'(CH); c++) begin
        cnt_q[c]     <= cnt_d[c];
        per_q[c]     <= per_d[c];
        duty_q[c]    <= duty_d[c];
        sh_per_q[c]  <= sh_per_d[c];
        sh_duty_q[c] <= sh_duty_d[c];
      end
    end
  end

`ifdef PWM_TONE_MIX_EN
  logic [MixW-1:0] mix_d, mix_q;

  // Popcount of the next pwm value so the registered count lines up with pwm_out.
  always_comb begin
    mix_d = '0;
    for (int c = 0; c < int'(CH); c++) begin
      mix_d = mix_d + MixW'(pwm_d[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix_count = mix_q;
`else
  assign mix_count = '0;
`endif

endmodule

// File: tb/tb_pwm_tone_bank.sv
// Self-checking bench for pwm_tone_bank: a per-channel behavioural model predicts
// every cycle's outputs into a scoreboard queue; a monitor pops and compares.
module tb_pwm_tone_bank;
  localparam int N  = 18;
  localparam int CH = 4;
  localparam int CW = $clog2(CH);
  localparam int MW = $clog2(CH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          load_valid;
  logic          load_ready;
  logic [CW-1:0] load_ch;
  logic [N-1:0]  load_period;
  logic [N-1:0]  load_duty;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] wrap;
  logic [MW-1:0] mix_count;

  pwm_tone_bank #(.N(N), .CH(CH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_ch    (load_ch),
    .load_period(load_period),
    .load_duty  (load_duty),
    .pwm_out    (pwm_out),
    .wrap       (wrap),
    .mix_count  (mix_count)
  );

  typedef struct {
    bit            chk;
    bit            ready;
    bit [CH-1:0]   wrap;
    bit [CH-1:0]   pwm;
    int            mix;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  // Model: each channel is a position within its current period plus an optional
  // staged (period, duty) that replaces the current one when a period completes.
  int          m_per [CH];
  int          m_duty[CH];
  int          m_pos [CH];
  int          m_sp  [CH];
  int          m_sd  [CH];
  bit          m_pend[CH];
  bit [CH-1:0] m_pwm;
  int          m_mix;
  bit          known = 1'b0;

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance the
  // model across the coming edge.
  task automatic cyc(bit rst, bit v, int ch, int p, int d);
    exp_t        e;
    bit          acc;
    bit [CH-1:0] lvl;
    int          pc;
    @(posedge clk);
    #1;
    reset       = rst;
    load_valid  = v;
    load_ch     = CW'(ch);
    load_period = N'(p);
    load_duty   = N'(d);

    e.chk   = known;
    e.ready = !m_pend[ch];
    e.pwm   = m_pwm;
    e.mix   = m_mix;
    for (int c = 0; c < CH; c++) e.wrap[c] = (m_per[c] > 0) && (m_pos[c] == m_per[c] - 1);
    sb.push_back(e);

    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_per[c] = 0; m_duty[c] = 0; m_pos[c] = 0; m_sp[c] = 0; m_sd[c] = 0; m_pend[c] = 0;
      end
      m_pwm = '0;
      m_mix = 0;
      known = 1'b1;
      return;
    end

    acc = v && !m_pend[ch];
    pc  = 0;
    for (int c = 0; c < CH; c++) begin
      lvl[c] = (m_per[c] > 0) && (m_pos[c] < m_duty[c]);
      if (lvl[c]) pc++;
      if (m_per[c] == 0) begin
        m_pos[c] = 0;
      end else if (m_pos[c] == m_per[c] - 1) begin
        m_pos[c] = 0;
        if (m_pend[c]) begin
          m_per[c] = m_sp[c]; m_duty[c] = m_sd[c]; m_pend[c] = 0;
        end
      end else begin
        m_pos[c]++;
      end
    end
    m_pwm = lvl;
`ifdef PWM_TONE_MIX_EN
    m_mix = pc;
`else
    m_mix = 0;
`endif
    if (acc) begin
      if (m_per[ch] == 0) begin
        m_per[ch] = p; m_duty[ch] = d; m_pos[ch] = 0;
      end else begin
        m_sp[ch] = p; m_sd[ch] = d; m_pend[ch] = 1;
      end
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // Monitor: compare every cycle's DUT outputs against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk) begin
          check("load_ready", int'(load_ready), int'(e.ready));
          check("wrap", int'(wrap), int'(e.wrap));
          check("pwm_out", int'(pwm_out), int'(e.pwm));
          check("mix_count", int'(mix_count), e.mix);
        end
      end
    end
  end

  initial begin
    int hi, wr, msum;
    reset = 1'b1; load_valid = 1'b0; load_ch = '0; load_period = '0; load_duty = '0;
    for (int c = 0; c < CH; c++) begin
      m_per[c] = 0; m_duty[c] = 0; m_pos[c] = 0; m_sp[c] = 0; m_sd[c] = 0; m_pend[c] = 0;
    end
    m_pwm = '0; m_mix = 0;
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);

    // ch0 P=10 D=3: 3 high / 7 low, one wrap per 10 cycles.
    cyc(0, 1, 0, 10, 3);
    idle(5);
    hi = 0; wr = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 0, 0, 0);
      if (pwm_out[0]) hi++;
      if (wrap[0]) wr++;
    end
    check("ch0_high_count", hi, 6);
    check("ch0_wrap_count", wr, 2);

    // ch1 P=8 D=4, reload mid-period, then a second load stalls while pending.
    cyc(0, 1, 1, 8, 4);
    idle(3);
    cyc(0, 1, 1, 4, 1);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 2, 1);
    idle(12);

    // ch2 duty above period (always high), then duty 0 after the next wrap.
    cyc(0, 1, 2, 5, 12);
    idle(4);
    cyc(0, 1, 2, 5, 0);
    idle(12);

    // Load ch0 exactly on its wrap cycle: old values persist one more period.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 0, 6, 2);
    for (int i = 0; i < 20 && !(m_pos[0] == 5); i++) idle(1);
    cyc(0, 1, 0, 3, 1);
    idle(16);

    // Align all channels to a common wrap, then switch them all to P=4 D=2.
    cyc(1, 0, 0, 0, 0);
    for (int c = 0; c < CH; c++) cyc(0, 1, c, 8 - c, 0);
    for (int c = 0; c < CH; c++) cyc(0, 1, c, 4, 2);
    idle(4);
    msum = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0);
      msum += int'(mix_count);
    end
`ifdef PWM_TONE_MIX_EN
    check("mix_sum", msum, 16);
`else
    check("mix_sum", msum, 0);
`endif

    // Reset while ch3 holds a pending load: the load must never appear.
    cyc(0, 1, 3, 9, 3);
    idle(2);
    cyc(0, 1, 3, 3, 1);
    cyc(1, 0, 0, 0, 0);
    idle(15);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(199) == 0), ($urandom_range(2) != 0), $urandom_range(CH - 1),
          $urandom_range(12), $urandom_range(14));
    end
    idle(3);
    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
